daqadcreader: RTL and testbench

Reads one conversion frame from the external ADC's parallel data bus after each conversion started by the DAQ trigger controller. It watches the ADC `busy_i` line; on each busy falling edge it drives `cs_n_o`/`rd_n_o` to read `NUM_CHANNELS` results in order. Each sample goes out over a valid/ready stream toward the sample FIFO and USB path. It is the read side of the CONVST/BUSY protocol whose trigger side already exists in the FPGA.

---
 rtl/daq_pkg.sv | 17 +
 rtl/daqsyncedge.sv | 19 +
 rtl/daqadcreader.sv | 119 +++++++++++
 tb/tb_daqadcreader.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/daq_pkg.sv
// daq_pkg: shared constants, ADC defaults and reader state encoding for the DAQ path
package daq_pkg;
  localparam logic HI = 1'b1;
  localparam logic LO = 1'b0;
  localparam int ADC_CHANNELS = 8;
  localparam int ADC_WIDTH = 16;
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_LOW  = 3'd1,
    S_PUSH    = 3'd2,
    S_RD_HIGH = 3'd3,
    S_DONE    = 3'd4
  } state_t;
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/daqsyncedge.sv
// daqsyncedge: 2-flop synchronizer, history flop and registered falling-edge pulse
module daqsyncedge (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic async_i,
  output logic fall_o
);
  logic [2:0] r_sh;
  // r_sh[0]/r_sh[1] synchronize, r_sh[2] holds the previous synchronized level; reset low so a line already low never fakes an edge
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_sh   <= 3'b000;
      fall_o <= 1'b0;
    end else begin
      r_sh   <= {r_sh[1:0], async_i};
      fall_o <= r_sh[2] & ~r_sh[1];
    end
  end
endmodule

// File: rtl/daqadcreader.sv
// daqadcreader: reads NUM_CHANNELS ADC results per BUSY fall and streams them out over valid/ready
module daqadcreader
  import daq_pkg::*;
#(
  parameter int NUM_CHANNELS   = ADC_CHANNELS,
  parameter int DATA_WIDTH     = ADC_WIDTH,
  parameter int RD_LOW_CYCLES  = 2,
  parameter int RD_HIGH_CYCLES = 2
) (
  input  logic                                clk_i,
  input  logic                                reset_n_i,
  input  logic                                en_i,
  input  logic                                busy_i,
  input  logic [DATA_WIDTH-1:0]               adc_db_i,
  output logic                                cs_n_o,
  output logic                                rd_n_o,
  output logic [DATA_WIDTH-1:0]               sample_o,
  output logic [idx_width(NUM_CHANNELS)-1:0]  chan_o,
  output logic                                valid_o,
  input  logic                                ready_i,
  output logic                                frame_done_o,
  output logic                                overrun_o
);
  localparam int CW   = idx_width(NUM_CHANNELS);
  localparam int MAXC = (RD_LOW_CYCLES > RD_HIGH_CYCLES) ? RD_LOW_CYCLES : RD_HIGH_CYCLES;
  localparam int KW   = $clog2(MAXC + 1);
  localparam logic [KW-1:0] LOW_LAST  = KW'(RD_LOW_CYCLES - 1);
  localparam logic [KW-1:0] HIGH_LAST = KW'(RD_HIGH_CYCLES - 1);
  localparam logic [CW-1:0] CH_LAST   = CW'(NUM_CHANNELS - 1);

  state_t                r_state, w_nxt;
  logic [KW-1:0]         r_cnt, w_cnt;
  logic [CW-1:0]         r_chan, w_chan;
  logic [DATA_WIDTH-1:0] r_sample, w_sample;
  logic                  w_fall, w_overrun;

  daqsyncedge u_busy_edge (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .async_i   (busy_i),
    .fall_o    (w_fall)
  );

  assign sample_o = r_sample;
  assign chan_o   = r_chan;

  // next state, counters and captured data; disable wins over everything and returns to reset values
  always_comb begin
    w_nxt     = r_state;
    w_cnt     = r_cnt;
    w_chan    = r_chan;
    w_sample  = r_sample;
    w_overrun = en_i & w_fall & (r_state != S_IDLE);
    if (!en_i) begin
      w_nxt    = S_IDLE;
      w_cnt    = '0;
      w_chan   = '0;
      w_sample = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_fall) begin
            w_nxt  = S_RD_LOW;
            w_cnt  = '0;
            w_chan = '0;
          end
        end
        S_RD_LOW: begin
          if (r_cnt == LOW_LAST) begin
            w_nxt    = S_PUSH;
            w_cnt    = '0;
            w_sample = adc_db_i;
          end else begin
            w_cnt = r_cnt + KW'(1);
          end
        end
        S_PUSH: begin
          if (ready_i) w_nxt = S_RD_HIGH;
        end
        S_RD_HIGH: begin
          if (r_cnt == HIGH_LAST) begin
            w_cnt  = '0;
            w_nxt  = (r_chan == CH_LAST) ? S_DONE : S_RD_LOW;
            w_chan = (r_chan == CH_LAST) ? r_chan : r_chan + CW'(1);
          end else begin
            w_cnt = r_cnt + KW'(1);
          end
        end
        S_DONE:  w_nxt = S_IDLE;
        default: w_nxt = S_IDLE;
      endcase
    end
  end

  // state register with outputs decoded from the next state so every output comes straight from a flop
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_chan       <= '0;
      r_sample     <= '0;
      cs_n_o       <= HI;
      rd_n_o       <= HI;
      valid_o      <= LO;
      frame_done_o <= LO;
      overrun_o    <= LO;
    end else begin
      r_state      <= w_nxt;
      r_cnt        <= w_cnt;
      r_chan       <= w_chan;
      r_sample     <= w_sample;
      cs_n_o       <= (w_nxt == S_RD_LOW || w_nxt == S_PUSH || w_nxt == S_RD_HIGH) ? LO : HI;
      rd_n_o       <= (w_nxt == S_RD_LOW) ? LO : HI;
      valid_o      <= (w_nxt == S_PUSH) ? HI : LO;
      frame_done_o <= (w_nxt == S_DONE) ? HI : LO;
      overrun_o    <= w_overrun;
    end
  end
endmodule

// File: tb/tb_daqadcreader.sv
// tb_daqadcreader: frame-level scoreboard for the ADC reader with table, random and corner sequences
module tb_daqadcreader;
  localparam int N  = 8;
  localparam int DW = 16;

  logic          clk_i = 1'b0;
  logic          reset_n_i = 1'b0;
  logic          en_i = 1'b0;
  logic          busy_i = 1'b0;
  logic [DW-1:0] adc_db_i = '0;
  logic          ready_i = 1'b1;
  logic          cs_n_o, rd_n_o, valid_o, frame_done_o, overrun_o;
  logic [DW-1:0] sample_o;
  logic [2:0]    chan_o;

  int vecs = 0;
  int errs = 0;

  typedef struct {
    int   stall_ch;
    int   stall_len;
    int   ovr_t;
    logic rnd;
    int   exp_ovr;
    int   exp_len;
  } vec_t;

  vec_t vt[6];

  daqadcreader dut (
    .clk_i        (clk_i),
    .reset_n_i    (reset_n_i),
    .en_i         (en_i),
    .busy_i       (busy_i),
    .adc_db_i     (adc_db_i),
    .cs_n_o       (cs_n_o),
    .rd_n_o       (rd_n_o),
    .sample_o     (sample_o),
    .chan_o       (chan_o),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .frame_done_o (frame_done_o),
    .overrun_o    (overrun_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // One frame: busy falls at negedge t=4, optional second fall at ovr_t; the ADC presents base+k for the k-th read
  task automatic run_frame(input int stall_ch, input int stall_len, input int ovr_t, input logic rnd,
                           input int exp_ovr, input int exp_len, input logic [DW-1:0] base);
    logic [DW-1:0] got_s[$];
    int            got_c[$];
    int cs_t = -1, done_t = -1, dones = 0, ovrs = 0, cs_falls = 0, stalls = 0, stall_err = 0, adc_idx = 0;
    logic cs_prev, rd_prev;
    cs_prev = cs_n_o;
    rd_prev = rd_n_o;
    for (int t = 0; t < 600; t++) begin
      @(negedge clk_i);
      if (cs_prev && !cs_n_o) begin
        cs_falls++;
        if (cs_t < 0) cs_t = t;
      end
      cs_prev = cs_n_o;
      if (frame_done_o) begin dones++; done_t = t; end
      if (overrun_o) ovrs++;
      if (!rd_prev && rd_n_o) adc_idx++;
      rd_prev = rd_n_o;
      if (t == 4) adc_idx = 0;
      adc_db_i = base + DW'(adc_idx);
      busy_i = (t < 4) || (ovr_t > 0 && t >= ovr_t - 4 && t < ovr_t);
      if (rnd) ready_i = ($urandom_range(0, 3) != 0);
      else     ready_i = !(valid_o && stall_ch >= 0 && int'(chan_o) == stall_ch && stalls < stall_len);
      if (valid_o && !ready_i) begin
        stalls++;
        if (rd_n_o !== 1'b1 || sample_o !== base + DW'(chan_o)) stall_err++;
      end
      if (valid_o && ready_i) begin
        got_s.push_back(sample_o);
        got_c.push_back(int'(chan_o));
      end
      if (done_t >= 0 && t >= done_t + 6 && t >= ovr_t + 6) break;
    end
    ready_i = 1'b1;
    check("latency", cs_t, 8);
    check("handshakes", got_s.size(), N);
    for (int i = 0; i < got_s.size() && i < N; i++) begin
      check("sample", got_s[i], base + DW'(i));
      check("chan", got_c[i], i);
    end
    check("frame_done_count", dones, 1);
    check("frame_len", done_t - cs_t + 1, (exp_len < 0) ? 41 + stalls : exp_len);
    check("overrun_count", ovrs, exp_ovr);
    check("cs_falls", cs_falls, 1);
    check("stall_hold", stall_err, 0);
  endtask

  initial begin
    int hs, cnt_cs, cnt_ovr, cnt_done, k;
    logic found;
    vt[0] = '{-1, 0,  0, 1'b0, 0, 41};
    vt[1] = '{ 3, 10, 0, 1'b0, 0, 51};
    vt[2] = '{-1, 0, 34, 1'b0, 1, 41};
    vt[3] = '{-1, 0, 45, 1'b0, 1, 41};
    vt[4] = '{ 0, 1,  0, 1'b0, 0, 42};
    vt[5] = '{ 7, 3, 34, 1'b0, 1, 44};

    repeat (2) @(negedge clk_i);
    check("rst_cs_n", cs_n_o, 1);
    check("rst_rd_n", rd_n_o, 1);
    check("rst_valid", valid_o, 0);
    check("rst_sample", sample_o, 0);
    check("rst_chan", chan_o, 0);
    check("rst_frame_done", frame_done_o, 0);
    check("rst_overrun", overrun_o, 0);
    reset_n_i = 1'b1;
    en_i = 1'b1;
    repeat (3) @(negedge clk_i);

    for (int i = 0; i < 6; i++) begin
      run_frame(vt[i].stall_ch, vt[i].stall_len, vt[i].ovr_t, vt[i].rnd, vt[i].exp_ovr, vt[i].exp_len, 16'h1000);
      repeat ($urandom_range(2, 6)) @(negedge clk_i);
    end

    for (int i = 0; i < 8; i++) begin
      run_frame(-1, 0, 0, 1'b1, 0, -1, DW'($urandom));
      repeat ($urandom_range(2, 9)) @(negedge clk_i);
    end

    busy_i = 1'b1;
    repeat (4) @(negedge clk_i);
    busy_i = 1'b0;
    found = 1'b0;
    for (int t = 0; t < 20 && !found; t++) begin
      @(negedge clk_i);
      found = !rd_n_o;
    end
    check("reset_reached_rd_low", found, 1);
    reset_n_i = 1'b0;
    #1;
    check("async_rst_cs_n", cs_n_o, 1);
    check("async_rst_rd_n", rd_n_o, 1);
    check("async_rst_valid", valid_o, 0);
    @(negedge clk_i);
    reset_n_i = 1'b1;
    cnt_cs = 0;
    repeat (20) begin
      @(negedge clk_i);
      if (!cs_n_o || valid_o || frame_done_o) cnt_cs++;
    end
    check("post_reset_idle", cnt_cs, 0);

    busy_i = 1'b1;
    repeat (4) @(negedge clk_i);
    busy_i = 1'b0;
    found = 1'b0;
    hs = 0;
    for (int t = 0; t < 100 && !found; t++) begin
      @(negedge clk_i);
      if (valid_o && ready_i) hs++;
      if (chan_o == 3'd2 && !rd_n_o) found = 1'b1;
    end
    check("disable_reached_chan2", found, 1);
    en_i = 1'b0;
    @(negedge clk_i);
    check("dis_cs_n", cs_n_o, 1);
    check("dis_rd_n", rd_n_o, 1);
    check("dis_valid", valid_o, 0);
    check("dis_sample", sample_o, 0);
    check("dis_chan", chan_o, 0);
    check("dis_handshakes", hs, 2);
    cnt_cs = 0;
    cnt_ovr = 0;
    cnt_done = 0;
    k = 0;
    repeat (20) begin
      busy_i = (k >= 2 && k < 6);
      k++;
      @(negedge clk_i);
      if (!cs_n_o) cnt_cs++;
      if (overrun_o) cnt_ovr++;
      if (frame_done_o) cnt_done++;
    end
    check("dis_no_activity", cnt_cs, 0);
    check("dis_no_overrun", cnt_ovr, 0);
    check("dis_no_done", cnt_done, 0);
    en_i = 1'b1;
    repeat (3) @(negedge clk_i);
    run_frame(-1, 0, 0, 1'b0, 0, 41, 16'h1000);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
